// File: rtl/swap_seq_pkg.sv
// Shared types and the byte transform used by the swap sequencer.
// Pure combinational helpers; no state lives here.
package swap_seq_pkg;

  typedef enum logic [1:0] {
    OP_SWAP = 2'b00,
    OP_PASS = 2'b01,
    OP_REV  = 2'b10,
    OP_INV  = 2'b11
  } op_t;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_ACK = 1'b1
  } state_t;

  localparam logic [7:0] UIO_OE = 8'hF0;

  function automatic logic [7:0] apply_op(op_t op, logic [7:0] d);
    logic [7:0] r;
    r = d;
    case (op)
      OP_SWAP: r = {d[3:0], d[7:4]};
      OP_PASS: r = d;
      OP_REV:  r = {d[0], d[1], d[2], d[3], d[4], d[5], d[6], d[7]};
      default: r = ~d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/swap_seq_fifo.sv
// Small circular FIFO, zero-latency read of the head entry (dout = mem[rd_ptr]).
// Push while full is accepted only if a pop happens in the same cycle; pop while empty is ignored.
module swap_seq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tt_um_swap_seq.sv
// Strobe-driven byte queue + transform; valid rises 4 edges after the wr pin (SYNC_FF=2).
// One result held until acked; writes into a full FIFO with no pop are dropped and flag overflow.
module tt_um_swap_seq
  import swap_seq_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int SYNC_FF = 2
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  logic [1:0]             sync_q [SYNC_FF];
  logic [1:0]             hist;
  logic [1:0]             pulse;
  logic                   wr_p;
  logic                   ack_p;
  logic                   push;
  logic                   pop;
  logic                   full;
  logic                   empty;
  logic                   valid;
  logic                   overflow;
  logic [9:0]             dout;
  logic [$clog2(DEPTH):0] fifo_count;
  state_t                 state;
  state_t                 state_nxt;
  logic                   unused_bits;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_FF; i++) sync_q[i] <= 2'b00;
      hist <= 2'b00;
    end else begin
      sync_q[0] <= uio_in[1:0];
      for (int i = 1; i < SYNC_FF; i++) sync_q[i] <= sync_q[i-1];
      hist <= sync_q[SYNC_FF-1];
    end
  end

  // The chain runs regardless of ena, so edges seen while disabled are consumed.
  assign pulse = sync_q[SYNC_FF-1] & ~hist;
  assign wr_p  = pulse[0];
  assign ack_p = pulse[1];
  assign push  = ena & wr_p;

  swap_seq_fifo #(.DEPTH(DEPTH), .WIDTH(10)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   ({uio_in[3:2], ui_in}),
    .dout  (dout),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (ena) begin
      case (state)
        ST_IDLE:     if (!empty) state_nxt = ST_WAIT_ACK;
        ST_WAIT_ACK: if (ack_p)  state_nxt = ST_IDLE;
        default:     state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    pop   = ena & (state == ST_IDLE) & ~empty;
    valid = (state == ST_WAIT_ACK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uo_out   <= 8'h00;
      overflow <= 1'b0;
    end else begin
      if (pop) uo_out <= apply_op(op_t'(dout[9:8]), dout[7:0]);
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  assign uio_out     = {overflow, empty, full, valid, 4'b0000};
  assign uio_oe      = UIO_OE;
  assign unused_bits = &{1'b0, uio_in[7:4], fifo_count};

endmodule
